// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the register-read stage, alu_seq and writeback.
// The master drives operands and out_ready; the slave (alu_seq) drives in_ready and the result.
interface alu_seq_if #(
    parameter int data_width = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] A;
    logic [data_width-1:0] B;
    logic [3:0]            FuncCode;
    logic                  MulSel;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] C;
    logic                  OverflowFlag;
    logic                  CarryFlag;
    logic                  ZeroFlag;
    logic                  NegFlag;

    modport master (
        output in_valid, A, B, FuncCode, MulSel, out_ready,
        input  in_ready, out_valid, C, OverflowFlag, CarryFlag, ZeroFlag, NegFlag
    );

    modport slave (
        input  in_valid, A, B, FuncCode, MulSel, out_ready,
        output in_ready, out_valid, C, OverflowFlag, CarryFlag, ZeroFlag, NegFlag
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, Z/N/C/V flags and a shift-add
// unsigned multiplier that retires one multiplier bit per cycle.
module alu_seq #(
    parameter  int data_width = 16,
    localparam int cnt_width  = $clog2(data_width) + 1
) (
    input logic      clk,
    input logic      reset_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0] FC_ZERO = 4'h0;
    localparam logic [3:0] FC_ID   = 4'h1;
    localparam logic [3:0] FC_NOT  = 4'h2;
    localparam logic [3:0] FC_AND  = 4'h3;
    localparam logic [3:0] FC_OR   = 4'h4;
    localparam logic [3:0] FC_XOR  = 4'h5;
    localparam logic [3:0] FC_NAND = 4'h6;
    localparam logic [3:0] FC_NOR  = 4'h7;
    localparam logic [3:0] FC_XNOR = 4'h8;
    localparam logic [3:0] FC_ADD  = 4'h9;
    localparam logic [3:0] FC_SUB  = 4'hA;
    localparam logic [3:0] FC_TCP  = 4'hB;
    localparam logic [3:0] FC_LLS  = 4'hC;
    localparam logic [3:0] FC_ALS  = 4'hD;
    localparam logic [3:0] FC_LRS  = 4'hE;
    localparam logic [3:0] FC_ARS  = 4'hF;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam int                     MSB      = data_width - 1;
    localparam logic [data_width-1:0]  ZERO_W   = {data_width{1'b0}};
    localparam logic [data_width-1:0]  ONE_W    = {{(data_width-1){1'b0}}, 1'b1};
    localparam logic [data_width-1:0]  MIN_NEG  = {1'b1, {(data_width-1){1'b0}}};
    localparam logic [data_width-1:0]  DW_LIM   = data_width'(data_width);
    localparam logic [cnt_width-1:0]   CNT_INIT = cnt_width'(data_width);
    localparam logic [cnt_width-1:0]   CNT_ONE  = {{(cnt_width-1){1'b0}}, 1'b1};
    localparam logic [2*data_width-1:0] ZERO_2W = {(2*data_width){1'b0}};

    logic [0:0]              r_state;
    logic [cnt_width-1:0]    r_cnt;
    logic [2*data_width-1:0] r_mcand;
    logic [2*data_width-1:0] r_prod;
    logic [data_width-1:0]   r_mplier;
    logic                    r_out_valid;
    logic [data_width-1:0]   r_c;
    logic                    r_ov;
    logic                    r_cy;
    logic                    r_zero;
    logic                    r_neg;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_mul_done;
    logic                    w_load;
    logic [data_width:0]     w_sum;
    logic [data_width:0]     w_diff;
    logic [data_width-1:0]   w_tcp;
    logic                    w_sh_oor;
    logic [cnt_width-1:0]    w_sh;
    logic [2*data_width-1:0] w_prod_next;
    logic [data_width-1:0]   w_alu_c;
    logic                    w_alu_ov;
    logic                    w_alu_cy;
    logic [data_width-1:0]   w_load_c;
    logic                    w_load_ov;
    logic                    w_load_cy;

    assign w_in_ready  = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_mul_done  = (r_state == S_MUL) && (r_cnt == CNT_ONE);
    assign w_load      = (w_accept && !bus.MulSel) || w_mul_done;
    assign w_sum       = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff      = {1'b0, bus.A} - {1'b0, bus.B};
    assign w_tcp       = ~bus.A + ONE_W;
    // In-range amounts are below data_width, so the low cnt_width bits carry the whole amount
    assign w_sh_oor    = (bus.B >= DW_LIM);
    assign w_sh        = bus.B[cnt_width-1:0];
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : ZERO_2W);

    // Single-cycle ALU result and arithmetic flags
    always_comb begin
        w_alu_c  = ZERO_W;
        w_alu_ov = 1'b0;
        w_alu_cy = 1'b0;
        case (bus.FuncCode)
            FC_ZERO: w_alu_c = ZERO_W;
            FC_ID:   w_alu_c = bus.A;
            FC_NOT:  w_alu_c = ~bus.A;
            FC_AND:  w_alu_c = bus.A & bus.B;
            FC_OR:   w_alu_c = bus.A | bus.B;
            FC_XOR:  w_alu_c = bus.A ^ bus.B;
            FC_NAND: w_alu_c = ~(bus.A & bus.B);
            FC_NOR:  w_alu_c = ~(bus.A | bus.B);
            FC_XNOR: w_alu_c = ~(bus.A ^ bus.B);
            FC_ADD: begin
                w_alu_c  = w_sum[MSB:0];
                w_alu_cy = w_sum[data_width];
                w_alu_ov = (bus.A[MSB] == bus.B[MSB]) && (w_sum[MSB] != bus.A[MSB]);
            end
            FC_SUB: begin
                w_alu_c  = w_diff[MSB:0];
                w_alu_cy = w_diff[data_width];
                w_alu_ov = (bus.A[MSB] != bus.B[MSB]) && (w_diff[MSB] != bus.A[MSB]);
            end
            FC_TCP: begin
                w_alu_c  = w_tcp;
                w_alu_ov = (bus.A == MIN_NEG);
            end
            FC_LLS, FC_ALS: begin
                if (w_sh_oor) w_alu_c = ZERO_W;
                else          w_alu_c = bus.A << w_sh;
            end
            FC_LRS: begin
                if (w_sh_oor) w_alu_c = ZERO_W;
                else          w_alu_c = bus.A >> w_sh;
            end
            FC_ARS: begin
                if (w_sh_oor) w_alu_c = {data_width{bus.A[MSB]}};
                else          w_alu_c = $unsigned($signed(bus.A) >>> w_sh);
            end
            default: w_alu_c = ZERO_W;
        endcase
    end

    // Choose what the output register captures: finished product or ALU result
    always_comb begin
        if (w_mul_done) begin
            w_load_c  = w_prod_next[MSB:0];
            w_load_ov = |w_prod_next[2*data_width-1:data_width];
            w_load_cy = 1'b0;
        end else begin
            w_load_c  = w_alu_c;
            w_load_ov = w_alu_ov;
            w_load_cy = w_alu_cy;
        end
    end

    // Control state and shift-add multiply datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= {cnt_width{1'b0}};
            r_mcand  <= ZERO_2W;
            r_mplier <= ZERO_W;
            r_prod   <= ZERO_2W;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && bus.MulSel) begin
                        r_state  <= S_MUL;
                        r_cnt    <= CNT_INIT;
                        r_mcand  <= {ZERO_W, bus.A};
                        r_mplier <= bus.B;
                        r_prod   <= ZERO_2W;
                    end
                end
                S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= {r_mcand[2*data_width-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[MSB:1]};
                    r_cnt    <= r_cnt - CNT_ONE;
                    if (w_mul_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output register: loads on a new result, holds under backpressure, drains on handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_c         <= ZERO_W;
            r_ov        <= 1'b0;
            r_cy        <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_c         <= w_load_c;
            r_ov        <= w_load_ov;
            r_cy        <= w_load_cy;
            r_zero      <= (w_load_c == ZERO_W);
            r_neg       <= w_load_c[MSB];
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.C            = r_c;
    assign bus.OverflowFlag = r_ov;
    assign bus.CarryFlag    = r_cy;
    assign bus.ZeroFlag     = r_zero;
    assign bus.NegFlag      = r_neg;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at data_width 16, 8 and 32 sharing one operand bus;
// expected results are hand-computed and queued at issue, a monitor pops them on handshake.
module tb_alu_seq;
    localparam logic [3:0] ZERO = 4'h0, ID = 4'h1, NOT = 4'h2, AND = 4'h3;
    localparam logic [3:0] OR = 4'h4, XOR = 4'h5, NAND = 4'h6, NOR = 4'h7;
    localparam logic [3:0] XNOR = 4'h8, ADD = 4'h9, SUB = 4'hA, TCP = 4'hB;
    localparam logic [3:0] LLS = 4'hC, ALS = 4'hD, LRS = 4'hE, ARS = 4'hF;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  fl;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n_s;
    logic [2:0]  vld_s;
    logic        out_ready_s;
    logic [31:0] a_s, b_s;
    logic [3:0]  f_s;
    logic        m_s;

    int   checks = 0;
    int   fails  = 0;
    exp_t q[3][$];

    alu_seq_if #(.data_width(16)) ifc16();
    alu_seq_if #(.data_width(8))  ifc8();
    alu_seq_if #(.data_width(32)) ifc32();

    assign ifc16.in_valid = vld_s[0];
    assign ifc8.in_valid  = vld_s[1];
    assign ifc32.in_valid = vld_s[2];
    assign ifc16.A = a_s[15:0];  assign ifc16.B = b_s[15:0];
    assign ifc8.A  = a_s[7:0];   assign ifc8.B  = b_s[7:0];
    assign ifc32.A = a_s;        assign ifc32.B = b_s;
    assign ifc16.FuncCode = f_s; assign ifc8.FuncCode = f_s; assign ifc32.FuncCode = f_s;
    assign ifc16.MulSel = m_s;   assign ifc8.MulSel = m_s;   assign ifc32.MulSel = m_s;
    assign ifc16.out_ready = out_ready_s;
    assign ifc8.out_ready  = out_ready_s;
    assign ifc32.out_ready = out_ready_s;

    alu_seq #(.data_width(16)) u16 (.clk(clk), .reset_n(rst_n_s), .bus(ifc16));
    alu_seq #(.data_width(8))  u8  (.clk(clk), .reset_n(rst_n_s), .bus(ifc8));
    alu_seq #(.data_width(32)) u32 (.clk(clk), .reset_n(rst_n_s), .bus(ifc32));

    always #5 clk = ~clk;

    function automatic int wd(input int s);
        case (s)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] get_c(input int s);
        case (s)
            0:       return {16'h0000, ifc16.C};
            1:       return {24'h000000, ifc8.C};
            default: return ifc32.C;
        endcase
    endfunction

    function automatic logic [3:0] get_fl(input int s);
        case (s)
            0:       return {ifc16.OverflowFlag, ifc16.CarryFlag, ifc16.ZeroFlag, ifc16.NegFlag};
            1:       return {ifc8.OverflowFlag, ifc8.CarryFlag, ifc8.ZeroFlag, ifc8.NegFlag};
            default: return {ifc32.OverflowFlag, ifc32.CarryFlag, ifc32.ZeroFlag, ifc32.NegFlag};
        endcase
    endfunction

    function automatic logic get_ov(input int s);
        case (s)
            0:       return ifc16.out_valid;
            1:       return ifc8.out_valid;
            default: return ifc32.out_valid;
        endcase
    endfunction

    function automatic logic get_rdy(input int s);
        case (s)
            0:       return ifc16.in_ready;
            1:       return ifc8.in_ready;
            default: return ifc32.in_ready;
        endcase
    endfunction

    task automatic chk(input string nm, input int s, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s w=%0d got=%h want=%h", nm, wd(s), got, want);
        end
    endtask

    // Issue one operation; fl = {overflow, carry, zero, neg}. MUL also checks latency and in_ready.
    task automatic op(input int s, input logic [3:0] f, input logic m, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic [3:0] fl, input string nm);
        int   n;
        bit   rdy_seen;
        exp_t e;
        f_s = f; m_s = m; a_s = a; b_s = b; vld_s[s] = 1'b1;
        n = 0;
        while (!get_rdy(s) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_accept"}, s, 64'(n < 50), 64'd1);
        e.c = c; e.fl = fl; e.nm = nm;
        q[s].push_back(e);
        @(posedge clk); #1;
        vld_s[s] = 1'b0;
        if (m) begin
            n = 0;
            rdy_seen = 1'b0;
            while (!get_ov(s) && n < 100) begin
                if (get_rdy(s)) rdy_seen = 1'b1;
                @(posedge clk); #1; n++;
            end
            chk({nm, "_latency"}, s, 64'(n), 64'(wd(s)));
            chk({nm, "_busy"}, s, 64'(rdy_seen), 64'd0);
        end
    endtask

    task automatic backpressure(input int s);
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        out_ready_s = 1'b0;
        op(s, ADD, 1'b0, 32'd1, 32'd1, 32'd2, 4'b0000, "bp_add");
        repeat (3) begin
            chk("bp_hold", s, {get_ov(s), get_rdy(s), get_c(s), get_fl(s)}, {1'b1, 1'b0, 32'd2, 4'b0000});
            @(posedge clk); #1;
        end
        f_s = SUB; m_s = 1'b0; a_s = 32'd5; b_s = 32'd5; vld_s[s] = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("bp_block", s, {get_ov(s), get_rdy(s), get_c(s), get_fl(s)}, {1'b1, 1'b0, 32'd2, 4'b0000});
        end
        out_ready_s = 1'b1;
        #1;
        chk("bp_release_rdy", s, 64'(get_rdy(s)), 64'd1);
        e.c = 32'd0; e.fl = 4'b0010; e.nm = "bp_sub";
        q[s].push_back(e);
        @(posedge clk); #1;
        vld_s[s] = 1'b0;
        chk("bp_next", s, {get_ov(s), get_c(s), get_fl(s)}, {1'b1, 32'd0, 4'b0010});
    endtask

    task automatic abort_mul(input int s);
        int n;
        bit seen;
        f_s = ADD; m_s = 1'b1; a_s = 32'd3; b_s = 32'd3; vld_s[s] = 1'b1;
        n = 0;
        while (!get_rdy(s) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("abort_accept", s, 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        vld_s[s] = 1'b0;
        repeat (wd(s) / 2) @(posedge clk);
        #1;
        rst_n_s = 1'b0;
        #1;
        chk("abort_reset_state", s, {get_ov(s), get_c(s), get_fl(s)}, {1'b0, 32'd0, 4'b0000});
        @(posedge clk); #1;
        rst_n_s = 1'b1;
        chk("abort_rdy", s, 64'(get_rdy(s)), 64'd1);
        seen = 1'b0;
        repeat (wd(s) + 4) begin
            @(posedge clk); #1;
            if (get_ov(s)) seen = 1'b1;
        end
        chk("abort_no_stale", s, 64'(seen), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_s = 1'b0; vld_s = 3'b000; out_ready_s = 1'b1;
        a_s = 32'd0; b_s = 32'd0; f_s = ZERO; m_s = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                for (int s = 0; s < 3; s++) begin
                    if (get_ov(s) && out_ready_s) begin
                        checks++;
                        if (q[s].size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_result w=%0d got C=%h", wd(s), get_c(s));
                        end else begin
                            e = q[s].pop_front();
                            if ({get_c(s), get_fl(s)} !== {e.c, e.fl}) begin
                                fails++;
                                $display("FAIL %s w=%0d got C=%h vczn=%b want C=%h vczn=%b",
                                         e.nm, wd(s), get_c(s), get_fl(s), e.c, e.fl);
                            end
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++)
            chk("reset_state", s, {get_ov(s), get_rdy(s), get_c(s), get_fl(s)}, {1'b0, 1'b1, 32'd0, 4'b0000});
        rst_n_s = 1'b1;
        @(posedge clk); #1;

        op(0, ADD, 1'b0, 32'h7FFF, 32'h0001, 32'h8000, 4'b1001, "add_ovf");
        chk("add_latency1", 0, 64'(get_ov(0)), 64'd1);
        op(0, ADD, 1'b0, 32'hFFFF, 32'h0001, 32'h0000, 4'b0110, "add_carry");
        op(0, SUB, 1'b0, 32'h8000, 32'h0001, 32'h7FFF, 4'b1000, "sub_ovf");
        op(0, SUB, 1'b0, 32'h0003, 32'h0005, 32'hFFFE, 4'b0101, "sub_borrow");
        op(0, SUB, 1'b0, 32'h0005, 32'h0005, 32'h0000, 4'b0010, "sub_zero");
        op(0, TCP, 1'b0, 32'h8000, 32'h0000, 32'h8000, 4'b1001, "tcp_minneg");
        op(0, TCP, 1'b0, 32'h0001, 32'h0000, 32'hFFFF, 4'b0001, "tcp_one");
        op(0, ARS, 1'b0, 32'h8000, 32'd20,   32'hFFFF, 4'b0001, "ars_oor");
        op(0, ARS, 1'b0, 32'h8000, 32'd4,    32'hF800, 4'b0001, "ars_4");
        op(0, LRS, 1'b0, 32'h8000, 32'd15,   32'h0001, 4'b0000, "lrs_15");
        op(0, LRS, 1'b0, 32'h8000, 32'hFFFF, 32'h0000, 4'b0010, "lrs_oor");
        op(0, LLS, 1'b0, 32'h0001, 32'd16,   32'h0000, 4'b0010, "lls_oor");
        op(0, ALS, 1'b0, 32'h4001, 32'd1,    32'h8002, 4'b0001, "als_1");
        op(0, AND, 1'b0, 32'hF0F0, 32'h3C3C, 32'h3030, 4'b0000, "and");
        op(0, OR,  1'b0, 32'hF0F0, 32'h3C3C, 32'hFCFC, 4'b0001, "or");
        op(0, XOR, 1'b0, 32'hF0F0, 32'h3C3C, 32'hCCCC, 4'b0001, "xor");
        op(0, NAND, 1'b0, 32'hF0F0, 32'h3C3C, 32'hCFCF, 4'b0001, "nand");
        op(0, NOR, 1'b0, 32'hF0F0, 32'h3C3C, 32'h0303, 4'b0000, "nor");
        op(0, XNOR, 1'b0, 32'hF0F0, 32'h3C3C, 32'h3333, 4'b0000, "xnor");
        op(0, NOT, 1'b0, 32'h0000, 32'h0000, 32'hFFFF, 4'b0001, "not");
        op(0, ID,  1'b0, 32'h1234, 32'h5678, 32'h1234, 4'b0000, "id");
        op(0, ZERO, 1'b0, 32'h1234, 32'h5678, 32'h0000, 4'b0010, "zero");
        op(0, ADD, 1'b1, 32'h00FF, 32'h0003, 32'h02FD, 4'b0000, "mul_small");
        op(0, ADD, 1'b1, 32'h0100, 32'h0100, 32'h0000, 4'b1010, "mul_hi");
        op(0, SUB, 1'b1, 32'hFFFF, 32'hFFFF, 32'h0001, 4'b1000, "mul_max");
        backpressure(0);
        abort_mul(0);

        op(1, ADD, 1'b0, 32'h7F, 32'h01, 32'h80, 4'b1001, "add_ovf");
        op(1, ADD, 1'b0, 32'hFF, 32'h01, 32'h00, 4'b0110, "add_carry");
        op(1, SUB, 1'b0, 32'h80, 32'h01, 32'h7F, 4'b1000, "sub_ovf");
        op(1, SUB, 1'b0, 32'h03, 32'h05, 32'hFE, 4'b0101, "sub_borrow");
        op(1, TCP, 1'b0, 32'h80, 32'h00, 32'h80, 4'b1001, "tcp_minneg");
        op(1, ARS, 1'b0, 32'h80, 32'd20, 32'hFF, 4'b0001, "ars_oor");
        op(1, LRS, 1'b0, 32'h80, 32'd7,  32'h01, 4'b0000, "lrs_7");
        op(1, LLS, 1'b0, 32'h01, 32'd8,  32'h00, 4'b0010, "lls_oor");
        op(1, ALS, 1'b0, 32'h41, 32'd1,  32'h82, 4'b0001, "als_1");
        op(1, ADD, 1'b1, 32'h0F, 32'h03, 32'h2D, 4'b0000, "mul_small");
        op(1, ADD, 1'b1, 32'h10, 32'h10, 32'h00, 4'b1010, "mul_hi");
        op(1, ADD, 1'b1, 32'hFF, 32'hFF, 32'h01, 4'b1000, "mul_max");
        backpressure(1);
        abort_mul(1);

        op(2, ADD, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, "add_ovf");
        op(2, ADD, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h00000000, 4'b0110, "add_carry");
        op(2, SUB, 1'b0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b1000, "sub_ovf");
        op(2, SUB, 1'b0, 32'h3, 32'h5, 32'hFFFFFFFE, 4'b0101, "sub_borrow");
        op(2, TCP, 1'b0, 32'h80000000, 32'h0, 32'h80000000, 4'b1001, "tcp_minneg");
        op(2, ARS, 1'b0, 32'h80000000, 32'd40, 32'hFFFFFFFF, 4'b0001, "ars_oor");
        op(2, LRS, 1'b0, 32'h80000000, 32'd31, 32'h00000001, 4'b0000, "lrs_31");
        op(2, LLS, 1'b0, 32'h1, 32'd32, 32'h0, 4'b0010, "lls_oor");
        op(2, ALS, 1'b0, 32'h40000001, 32'd1, 32'h80000002, 4'b0001, "als_1");
        op(2, ADD, 1'b1, 32'h0000FFFF, 32'h3, 32'h0002FFFD, 4'b0000, "mul_small");
        op(2, ADD, 1'b1, 32'h00010000, 32'h00010000, 32'h0, 4'b1010, "mul_hi");
        op(2, ADD, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 4'b0001, "mul_wide");
        backpressure(2);
        abort_mul(2);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++)
            chk("queue_drained", s, 64'(q[s].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 16-bit ALU.
- Wraps the same 16 FuncCode operations, with codes taken from the alu_func.v macros, in a valid/ready handshake with a single output register.
- Adds registered Zero/Negative/Carry flags, a corrected subtract-overflow rule, defined out-of-range shift behaviour, and an iterative unsigned multiply (shift-add, one bit per cycle).
- Sits between the register-file read stage and writeback of the multi-cycle CPU datapath.

Parameters:
- data_width, 16, operand/result width in bits (must be >= 2).
- cnt_width, $clog2(data_width)+1, width of the multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept this cycle
- A  input  data_width  operand A
- B  input  data_width  operand B / shift amount
- FuncCode  input  4  alu_func.v opcode; ignored when MulSel=1
- MulSel  input  1  1 = unsigned multiply A*B
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- C  output  data_width  result
- OverflowFlag  output  1  signed overflow / multiply high-half nonzero
- CarryFlag  output  1  add carry-out / subtract borrow
- ZeroFlag  output  1  C == 0
- NegFlag  output  1  C[data_width-1]

Behaviour:
- Reset (async, reset_n=0): state=IDLE, out_valid=0, C=0, all flags 0, counter and multiply accumulators 0. Reset mid-multiply discards the operation.
- States: IDLE, MUL.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Output register: when out_valid=1 and out_ready=0, C and all flags hold stable. out_valid clears on an out_ready handshake unless a new result loads on the same edge.
- IDLE, accept with MulSel=0: result and flags loaded on the accept edge; out_valid=1 the next cycle (latency 1). Back-to-back accepts every cycle are allowed when out_ready=1.
- IDLE, accept with MulSel=1: latch A, B, clear the 2*data_width-bit product; go to MUL with counter = data_width.
- MUL: each edge adds the shifted multiplicand if the current multiplier bit is 1, then shifts; counter decrements. On the edge where the counter reaches 0: C = product[data_width-1:0], OverflowFlag = |product[2*data_width-1:data_width], CarryFlag=0, out_valid=1, state=IDLE.
- Multiply latency: out_valid is seen high exactly data_width cycles after the accept edge. in_ready=0 throughout MUL.
- ADD: C = A+B. CarryFlag = carry-out. OverflowFlag = (A[msb]==B[msb]) && (C[msb]!=A[msb]).
- SUB: C = A-B. CarryFlag = borrow (A<B unsigned). OverflowFlag = (A[msb]!=B[msb]) && (C[msb]!=A[msb]).
- TCP: C = ~A+1. OverflowFlag = 1 only when A is the most-negative value.
- All other ops: CarryFlag = 0, OverflowFlag = 0.
- Logic, ID, NOT, ZERO: as the combinational ALU. Undefined codes give C=0.
- Shifts: the amount is the full unsigned B.
  - LLS, ALS, LRS: an amount >= data_width gives C=0.
  - ARS: an amount >= data_width gives all bits = A[msb]. ARS treats A as signed.
  - ALS is identical to LLS.
- ZeroFlag and NegFlag are derived from the loaded C for every operation, including multiply.
- Inputs are sampled only on accept; A, B, FuncCode and MulSel may change freely during MUL.

Test Plan:
- ADD 0x7FFF+0x0001 -> next cycle out_valid=1, C=0x8000, Overflow=1, Neg=1, Carry=0, Zero=0. ADD 0xFFFF+0x0001 -> C=0, Carry=1, Zero=1, Overflow=0.
- SUB 0x8000-0x0001 -> C=0x7FFF, Overflow=1. SUB 0x0003-0x0005 -> C=0xFFFE, Carry=1, Overflow=0. SUB 5-5 -> Zero=1. TCP 0x8000 -> C=0x8000, Overflow=1.
- Shifts: ARS 0x8000 by 20 -> 0xFFFF. LRS 0x8000 by 15 -> 0x0001. LLS 0x0001 by 16 -> 0x0000. ALS 0x4001 by 1 -> 0x8002.
- MUL 0x00FF*0x0003 -> in_ready=0 for 16 cycles, then C=0x02FD, Overflow=0. MUL 0x0100*0x0100 -> C=0x0000, Overflow=1, Zero=1.
- Backpressure: hold out_ready=0 after an ADD -> C and flags stable, in_ready=0, a second in_valid is not accepted. Raise out_ready -> second op accepted that same cycle and its result appears the next cycle.
- Assert reset_n=0 for 1 cycle mid-MUL (counter=8) -> out_valid=0, C=0, all flags 0, in_ready=1 after release, no stale result emitted. Repeat all of the above at data_width=8 and 32.
